// File: rtl/cpu_defs.sv
// Shared CPU constants and the fetch-queue entry layout.
package cpu_defs;

  localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_WORDS   = 4096;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP        = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with show-ahead head, clear and occupancy count.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-side prefetch queue: captures {pc, instr, exc} each cycle, feeds decode,
// back-pressures the PC register and drops wrong-path entries on redirect.
module fetch_buffer
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] IM_BASE  = PC_DEFAULT,
  parameter int unsigned IM_WORDS = cpu_defs::IM_WORDS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              instr_in,
  output logic                     pc_en,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_instr,
  output logic                     id_exc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned WIDTH  = $bits(fetch_entry_t);
  // 33 bits so the end of IM cannot wrap around the 32-bit space.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

  fetch_entry_t wr_entry, head;
  logic [WIDTH-1:0] head_raw;
  logic exc, push, pop, full, empty;

  assign exc = (pc_in[1:0] != 2'b00) | (pc_in < IM_BASE) | ({1'b0, pc_in} >= IM_END);

  always_comb begin
    wr_entry.pc    = pc_in;
    wr_entry.instr = exc ? NOP : instr_in;
    wr_entry.exc   = exc;
  end

  assign push  = ~reset & ~flush & ~full;
  assign pop   = id_valid & id_ready & ~flush;
  assign pc_en = flush | ~full;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_raw),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign head     = fetch_entry_t'(head_raw);
  assign id_valid = ~empty;
  assign id_pc    = head.pc;
  assign id_instr = head.instr;
  assign id_exc   = head.exc;

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Consumer end of the program-counter interface.
- Each cycle it takes the current PC and the instruction read from IM at that PC, and queues them as {pc, instr, exc} entries in a small prefetch FIFO.
- It presents the queue head to the decode stage over a valid/ready handshake.
- It drives the PC update enable back to the PC register, which gives backpressure, and discards all queued wrong-path entries on a branch/jump redirect (flush).

Parameters:
- DEPTH, 4: FIFO entries, power of two, >= 2.
- IM_BASE, 32'h0000_3000: first valid instruction address; equals the PC reset value.
- IM_WORDS, 4096: IM size in 32-bit words; the valid range is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous reset, active-high.
- pc_in, input, 32: current PC register value.
- instr_in, input, 32: IM read data for pc_in (combinational, same cycle).
- pc_en, output, 1: PC register update enable.
- flush, input, 1: redirect this cycle; the PC loads its redirect target at the same edge.
- id_ready, input, 1: decode accepts the head entry this cycle.
- id_valid, output, 1: head entry valid.
- id_pc, output, 32: head entry PC.
- id_instr, output, 32: head entry instruction.
- id_exc, output, 1: head entry fetch exception (AdEL on fetch).
- count, output, log2(DEPTH)+1: current occupancy.

Behaviour:
- Interface: one clock domain, clk. reset is synchronous and active-high, sampled only at the rising edge of clk. No asynchronous reset anywhere.
- Reset: rd_ptr = wr_ptr = 0 and count = 0. Outputs: id_valid = 0, id_pc = 0, id_instr = 0, id_exc = 0, pc_en = 1. Storage contents are don't-care. reset has priority over flush, push and pop.
- full = (count == DEPTH); empty = (count == 0).
- pc_en = flush | ~full. This is combinational. During a flush the PC always loads its target, even when the FIFO is full.
- push = ~reset & ~flush & ~full. When push is set, the entry {pc_in, instr_or_nop, exc} is written at wr_ptr and wr_ptr advances.
- exc = (pc_in[1:0] != 0) | (pc_in < IM_BASE) | (pc_in >= IM_BASE + 4*IM_WORDS). When exc = 1, the stored instruction is 32'h0 (nop) and instr_in is ignored.
- pop = id_valid & id_ready & ~flush. When pop is set, rd_ptr advances.
- Head outputs are show-ahead from storage at rd_ptr.
  - id_valid = ~empty.
  - When empty, id_pc, id_instr and id_exc are forced to 0.
  - An entry pushed at edge N is visible on id_* in the cycle after edge N. There is no fall-through bypass from pc_in to id_*.
- Occupancy update: count_next = count + push - pop. When push and pop happen together, count is unchanged.
- Full rule: when count == DEPTH, push = 0 even if pop = 1. The PC stalls for one cycle and the entry is refetched afterwards. Accepted cost: no same-cycle refill when full.
- Flush: at the edge, count = 0 and rd_ptr = wr_ptr = 0. No push and no pop that cycle. The in-flight pc_in/instr_in are dropped, and id_valid = 0 in the next cycle. A redirect-target entry is pushed starting on the next cycle.
- Flush while empty: harmless; state stays empty.
- Pointer wrap: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count disambiguates full from empty.
- Handshake stability: while id_valid = 1, id_ready = 0 and no flush, id_pc, id_instr and id_exc hold stable.
- No X on any output after reset.

Decomposition:
- Shared package (cpu_defs):
  - PC_DEFAULT = 32'h0000_3000; IM_BASE defaults to it.
  - IM_WORDS.
  - EXC_ADEL = 5'd4 for downstream CP0 encoding.
  - NOP = 32'h0.
- One sub-module: fetch_fifo.
  - Generic DEPTH x WIDTH synchronous FIFO with push, pop, clear, count, and show-ahead head.
  - fetch_buffer wraps fetch_fifo with the pc_en, flush and exception logic; WIDTH = 65.

Test Plan:
1. Reset, then id_ready = 1 with pc_in stepping 0x3000, 0x3004, ... and instr_in = pc_in ^ 0xFFFF -> id_valid rises one cycle after the first push; id_pc is 0x3000, 0x3004, ... with no gaps; count stays at 1; pc_en stays 1.
2. id_ready = 0 for 6 cycles -> count goes 1, 2, 3, 4 and then holds; pc_en = 0 once count = 4. id_pc stays 0x3000 and stable. Raising id_ready drains in order 0x3000, 0x3004, 0x3008, 0x300C.
3. FIFO full (count = 4) with flush = 1 and pc_in = 0x3010 -> next cycle count = 0 and id_valid = 0, with pc_en = 1 during the flush cycle. After the PC takes the redirect target (driven by the bench as pc_in = 0x3400), id_pc = 0x3400 in the following cycle.
4. pc_in = 0x3002, then 0x2FFC, then 0x7000 (IM_WORDS = 4096) -> each entry shows id_exc = 1 and id_instr = 0x00000000; pc_in = 0x6FFC gives id_exc = 0.
5. count = 4 with id_ready = 1 (pop and attempted push in the same cycle) -> push is suppressed; count goes 4, then 3; the entry is accepted on the next cycle and the final order has no duplicates or losses.
6. Assert reset in the middle of streaming, with count = 3 and flush = 1 at the same time -> next cycle all outputs are 0, count = 0 and pc_en = 1. Streaming after release starts again from 0x3000.
